branch_update_queue: RTL and testbench
======================================

// Module: branch_update_queue
// PURPOSE
//  Buffers resolved-branch outcomes from execute and replays them one per cycle into the
//  GShare predictor's update port (update_en / update_val). Decouples execute, which may
//  resolve branches back-to-back, from a predictor that can stall updates via upd_rdy.
//  Sits directly upstream of the GShare datapath/control update inputs.
// PARAMETERS
//  DEPTH  4   queue entries; must be a power of 2, >= 2
//  PC_W   32  branch PC width carried with each entry
// PORTS
//  clk            in   1             clock; all state updates on posedge
//  reset          in   1             synchronous, active-high
//  resolve_val    in   1             execute presents a resolved branch
//  resolve_rdy    out  1             queue can accept an entry this cycle
//  resolve_pc     in   PC_W          PC of resolved branch
//  resolve_taken  in   1             actual outcome (1 = taken)
//  upd_en         out  1             head entry valid; drives predictor update_en
//  upd_rdy        in   1             predictor consumes head this cycle
//  upd_pc         out  PC_W          head PC (PHT/GHR index source)
//  upd_taken      out  1             head outcome; drives predictor update_val
//  flush          in   1             discard all buffered entries
//  count          out  $clog2(DEPTH+1)  entries currently held
//  full           out  1             count == DEPTH
//  empty          out  1             count == 0
// BEHAVIOUR
//  - Circular buffer: head/tail pointers of $clog2(DEPTH) bits, wrap modulo DEPTH; count is
//    tracked separately (no pointer-MSB trick).
//  - Enqueue fire = resolve_val && resolve_rdy; writes {resolve_pc, resolve_taken} at tail,
//    tail++. Dequeue fire = upd_en && upd_rdy; head++.
//  - resolve_rdy = !full && !flush. No combinational path from upd_rdy to resolve_rdy: when
//    full, a same-cycle dequeue does NOT allow enqueue.
//  - upd_en = !empty; upd_pc/upd_taken = storage[head]; all purely from registered state.
//    No bypass: entry enqueued in cycle N is first visible on upd_* in cycle N+1.
//  - Simultaneous enqueue + dequeue (0 < count < DEPTH): both fire, count unchanged.
//  - Outputs hold stable while upd_en && !upd_rdy (predictor stall); order strictly FIFO.
//  - upd_taken/upd_pc are don't-care while empty; bench must not check them.
//  - flush (sync): next cycle head = tail = 0, count = 0; a dequeue in the flush cycle is
//    still reported by upd_en (predictor may consume it); the enqueue is blocked.
//  - Occupancy states EMPTY -> PARTIAL -> FULL, transitions only by +/-1 per cycle, or any
//    -> EMPTY on flush/reset.
//  - Reset: head = tail = count = 0; upd_en = 0, empty = 1, full = 0, resolve_rdy = 1 the
//    cycle after reset deasserts (resolve_rdy = 0 while reset high). Storage not cleared.
//  - Reset mid-operation discards all entries exactly as flush.
//  - resolve_* inputs must be stable only when resolve_val; upd_rdy may toggle freely.
// STRUCTURE
//  - lab4_branch_pkg: typedef struct packed { logic [PC_W-1:0] pc; logic taken; }
//    br_upd_entry_t; localparam for default DEPTH.
//  - Sub-module branch_update_queue_regs: DEPTH x br_upd_entry_t register array, 1 write
//    port (wen, waddr), 1 combinational read port (raddr). Pointer/count control in top.
// TESTING
//  1 Reset, then resolve 0x100/taken with upd_rdy=1 -> upd_en=1 next cycle with
//    upd_pc=0x100, upd_taken=1; empty again the cycle after.
//  2 upd_rdy=0, enqueue 4 entries (0x10,0x20,0x30,0x40) -> full=1, resolve_rdy=0, count=4;
//    5th resolve_val held until a dequeue frees space.
//  3 Full queue, assert upd_rdy and resolve_val same cycle -> dequeue only, count=3;
//    enqueue accepted following cycle.
//  4 Count=2, simultaneous enqueue+dequeue for 6 cycles -> count stays 2, pointers wrap,
//    upd_pc sequence matches enqueue order.
//  5 Count=3, assert flush with upd_rdy=1 and resolve_val=1 -> head consumed that cycle,
//    enqueue blocked, next cycle empty=1, count=0.
//  6 Reset asserted with count=2 -> next cycle upd_en=0, count=0, full=0.

Source files
------------

// File: rtl/lab4_branch_pkg.sv
// Shared types for the branch update queue: queue entry layout and occupancy states.
package lab4_branch_pkg;

   localparam int BUQ_DEPTH = 4;
   localparam int BR_PC_W   = 32;

   typedef struct packed {
      logic [BR_PC_W-1:0] pc;
      logic               taken;
   } br_upd_entry_t;

   typedef enum logic [1:0] {
      OCC_EMPTY   = 2'd0,
      OCC_PARTIAL = 2'd1,
      OCC_FULL    = 2'd2
   } occ_state_t;

endpackage

// File: rtl/branch_update_queue_regs.sv
// Entry storage for the branch update queue: one write port, one combinational read port.
module branch_update_queue_regs
   import lab4_branch_pkg::*;
#(
   parameter int DEPTH = BUQ_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          wen,
   input  logic [AW-1:0] waddr,
   input  br_upd_entry_t wdata,
   input  logic [AW-1:0] raddr,
   output br_upd_entry_t rdata
);

   // No reset: entries are only observable through upd_en, which tracks count.
   br_upd_entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (wen) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/branch_update_queue.sv
// Circular buffer replaying resolved-branch outcomes into the GShare update port, one per cycle.
module branch_update_queue
   import lab4_branch_pkg::*;
#(
   parameter int DEPTH = BUQ_DEPTH,
   parameter int PC_W  = BR_PC_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       resolve_val,
   output logic                       resolve_rdy,
   input  logic [PC_W-1:0]            resolve_pc,
   input  logic                       resolve_taken,
   output logic                       upd_en,
   input  logic                       upd_rdy,
   output logic [PC_W-1:0]            upd_pc,
   output logic                       upd_taken,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   occ_state_t    state_q, state_d;
   logic          enq, deq;
   br_upd_entry_t wr_entry, rd_entry;

   // Ready depends only on registered occupancy, so a same-cycle dequeue never frees a full queue.
   assign resolve_rdy = !full && !flush && !reset;
   assign enq         = resolve_val && resolve_rdy;
   assign deq         = upd_en && upd_rdy;

   assign wr_entry.pc    = resolve_pc;
   assign wr_entry.taken = resolve_taken;

   branch_update_queue_regs #(.DEPTH(DEPTH), .AW(PW)) u_regs (
      .clk   (clk),
      .wen   (enq),
      .waddr (tail_q),
      .wdata (wr_entry),
      .raddr (head_q),
      .rdata (rd_entry)
   );

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (enq) tail_d = tail_q + PW'(1);
         if (deq) head_d = head_q + PW'(1);
         count_d = count_q + CW'(enq) - CW'(deq);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         state_q <= OCC_EMPTY;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = OCC_PARTIAL;
      if (count_d == '0)              state_d = OCC_EMPTY;
      else if (count_d == CW'(DEPTH)) state_d = OCC_FULL;
   end

   always_comb begin
      full  = 1'b0;
      empty = 1'b0;
      case (state_q)
         OCC_EMPTY: empty = 1'b1;
         OCC_FULL:  full  = 1'b1;
         default: ;
      endcase
   end

   assign upd_en    = !empty;
   assign upd_pc    = rd_entry.pc;
   assign upd_taken = rd_entry.taken;
   assign count     = count_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Randomized and directed bench for branch_update_queue against a queue-based reference model.
module tb_branch_update_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;
   localparam int CW    = $clog2(DEPTH+1);

   logic            clk = 1'b0;
   logic            reset, resolve_val, resolve_taken, upd_rdy, flush;
   logic [PC_W-1:0] resolve_pc;
   logic            resolve_rdy, upd_en, upd_taken, full, empty;
   logic [PC_W-1:0] upd_pc;
   logic [CW-1:0]   count;

   int checks = 0;
   int errors = 0;
   logic [PC_W:0] mq [$];

   always #5 clk = ~clk;

   branch_update_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk           (clk),
      .reset         (reset),
      .resolve_val   (resolve_val),
      .resolve_rdy   (resolve_rdy),
      .resolve_pc    (resolve_pc),
      .resolve_taken (resolve_taken),
      .upd_en        (upd_en),
      .upd_rdy       (upd_rdy),
      .upd_pc        (upd_pc),
      .upd_taken     (upd_taken),
      .flush         (flush),
      .count         (count),
      .full          (full),
      .empty         (empty)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive inputs, check outputs against the model, advance the model on the edge.
   task automatic step(input logic rst, input logic rv, input logic [PC_W-1:0] pc,
                       input logic tk, input logic ur, input logic fl);
      logic exp_rdy;
      reset = rst; resolve_val = rv; resolve_pc = pc; resolve_taken = tk;
      upd_rdy = ur; flush = fl;
      #1;
      exp_rdy = (mq.size() < DEPTH) && !fl && !rst;
      chk("resolve_rdy", resolve_rdy, exp_rdy);
      chk("upd_en", upd_en, mq.size() != 0);
      chk("count", count, mq.size());
      chk("full", full, mq.size() == DEPTH);
      chk("empty", empty, mq.size() == 0);
      if (mq.size() != 0) begin
         chk("upd_pc", upd_pc, mq[0][PC_W:1]);
         chk("upd_taken", upd_taken, mq[0][0]);
      end
      @(posedge clk);
      if (rst) mq.delete();
      else begin
         if (mq.size() != 0 && ur) void'(mq.pop_front());
         if (fl) mq.delete();
         else if (rv && exp_rdy) mq.push_back({pc, tk});
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic ur);
      step(1'b0, 1'b0, '0, 1'b0, ur, 1'b0);
   endtask

   task automatic push(input logic [PC_W-1:0] pc, input logic tk, input logic ur);
      step(1'b0, 1'b1, pc, tk, ur, 1'b0);
   endtask

   initial begin
      reset = 1'b1; resolve_val = 1'b0; resolve_pc = '0; resolve_taken = 1'b0;
      upd_rdy = 1'b0; flush = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("rst_rdy_low", resolve_rdy, 1'b0);
      chk("rst_upd_en", upd_en, 1'b0);
      @(negedge clk);

      // 1: single entry visible next cycle, consumed, then empty
      idle(1'b1);
      push(32'h100, 1'b1, 1'b1);
      chk("t1_upd_pc", upd_pc, 32'h100);
      chk("t1_upd_taken", upd_taken, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // 2: fill under stall, fifth held off
      for (int i = 1; i <= 4; i++) push(PC_W'(i * 16), i[0], 1'b0);
      chk("t2_count", count, 4);
      chk("t2_full", full, 1'b1);
      push(32'h50, 1'b0, 1'b0);
      push(32'h50, 1'b0, 1'b0);

      // 3: full, dequeue + resolve same cycle -> dequeue only, then accepted
      push(32'h50, 1'b0, 1'b1);
      chk("t3_count", count, 3);
      chk("t3_head", upd_pc, 32'h20);
      push(32'h50, 1'b0, 1'b0);
      chk("t3_count_after", count, 4);

      // 4: count 2, six simultaneous enq+deq, pointers wrap
      idle(1'b1);
      idle(1'b1);
      chk("t4_count2", count, 2);
      for (int i = 0; i < 6; i++) push(PC_W'(32'h60 + i), i[1], 1'b1);
      chk("t4_count_hold", count, 2);
      chk("t4_head", upd_pc, 32'h64);

      // 5: count 3, flush with dequeue and resolve
      push(32'h70, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h80, 1'b1, 1'b1, 1'b1);
      chk("t5_empty", empty, 1'b1);
      chk("t5_count", count, 0);
      idle(1'b0);

      // 6: reset mid-operation with two entries
      push(32'h90, 1'b0, 1'b0);
      push(32'hA0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
      chk("t6_upd_en", upd_en, 1'b0);
      chk("t6_count", count, 0);
      chk("t6_full", full, 1'b0);
      idle(1'b0);

      for (int n = 0; n < 3000; n++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 99) < 60,
              $urandom,
              $urandom_range(0, 1),
              $urandom_range(0, 99) < 45,
              $urandom_range(0, 99) < 4);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
